// File: rtl/md_pkg.sv
// ============================================================================
// Module      : md_pkg
// Description : Shared op encodings, default latencies and md-class decode
//               helper for the execute-stage multiply/divide unit.
//               Optional feature macro: MD_MADD_EN (ops 6/7 = MADD/MADDU).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    localparam logic [2:0] MD_MADD  = 3'd6;
    localparam logic [2:0] MD_MADDU = 3'd7;

    localparam int MD_MULT_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF  = 10;

    typedef enum logic [1:0] {
        MD_CLS_NONE = 2'd0,
        MD_CLS_MUL  = 2'd1,
        MD_CLS_DIV  = 2'd2,
        MD_CLS_MOVE = 2'd3
    } md_class_e;

    // Shared with the hazard unit so both sides agree on which ops go multi-cycle.
    function automatic md_class_e md_decode(input logic [2:0] op);
        md_class_e cls;
        cls = MD_CLS_NONE;
        case (op)
            MD_MULT, MD_MULTU: cls = MD_CLS_MUL;
            MD_DIV,  MD_DIVU:  cls = MD_CLS_DIV;
            MD_MTHI, MD_MTLO:  cls = MD_CLS_MOVE;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU: cls = MD_CLS_MUL;
`endif
            default:           cls = MD_CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_arith.sv
// ============================================================================
// Module      : md_arith
// Description : Combinational 64-bit product / quotient-remainder datapath.
//               Optional feature macro: MD_MADD_EN (products for ops 6/7).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_result,
    output logic        o_div_zero
);

    logic        w_signed_op;
    logic [63:0] w_ma;
    logic [63:0] w_mb;
    logic [63:0] w_prod;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_dvs;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;

    assign w_signed_op = (i_op == MD_MULT) || (i_op == MD_DIV) || (i_op == MD_MADD);

    assign w_ma   = w_signed_op ? {{32{i_a[31]}}, i_a} : {32'b0, i_a};
    assign w_mb   = w_signed_op ? {{32{i_b[31]}}, i_b} : {32'b0, i_b};
    assign w_prod = w_ma * w_mb;

    // Sign-magnitude division: 0x80000000 / -1 wraps to 0x80000000 with no trap.
    assign w_neg_a = w_signed_op && i_a[31];
    assign w_neg_b = w_signed_op && i_b[31];
    assign w_mag_a = w_neg_a ? (32'd0 - i_a) : i_a;
    assign w_mag_b = w_neg_b ? (32'd0 - i_b) : i_b;
    assign w_dvs   = (i_b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_uq    = w_mag_a / w_dvs;
    assign w_ur    = w_mag_a % w_dvs;
    assign w_q     = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
    assign w_r     = w_neg_a ? (32'd0 - w_ur) : w_ur;

    assign o_div_zero = (i_b == 32'd0);

    always_comb begin
        o_result = 64'd0;
        case (i_op)
            MD_MULT, MD_MULTU: o_result = w_prod;
            MD_DIV,  MD_DIVU:  o_result = {w_r, w_q};
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU: o_result = w_prod;
`endif
            default:           o_result = 64'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// Module      : md_unit
// Description : Execute-stage multiply/divide unit with HI/LO registers and
//               multi-cycle latency modelling. Optional feature macro:
//               MD_MADD_EN (ops 6/7 accumulate into {hi,lo}).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit
    import md_pkg::*;
#(
    parameter int MULT_LAT = MD_MULT_LAT_DEF,
    parameter int DIV_LAT  = MD_DIV_LAT_DEF
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    localparam logic [CNT_W-1:0] c_mult_lat = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] c_div_lat  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_rhi;
    logic [31:0]      r_rlo;
    logic             r_upd;
`ifdef MD_MADD_EN
    logic             r_acc;
`endif

    md_class_e   w_cls;
    logic [63:0] w_result;
    logic        w_div_zero;
    logic [63:0] w_commit;
    logic        w_busy;

    md_arith u_arith (
        .i_op       (op),
        .i_a        (a),
        .i_b        (b),
        .o_result   (w_result),
        .o_div_zero (w_div_zero)
    );

    assign w_cls  = md_decode(op);
    assign w_busy = (r_cnt != '0);

`ifdef MD_MADD_EN
    // Accumulate against hi/lo as they stand at commit, not at issue.
    assign w_commit = r_acc ? ({r_hi, r_lo} + {r_rhi, r_rlo}) : {r_rhi, r_rlo};
`else
    assign w_commit = {r_rhi, r_rlo};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
            r_rhi <= 32'd0;
            r_rlo <= 32'd0;
            r_upd <= 1'b0;
`ifdef MD_MADD_EN
            r_acc <= 1'b0;
`endif
        end else if (w_busy) begin
            // Any start while busy falls through here and is dropped.
            r_cnt <= r_cnt - c_one;
            if ((r_cnt == c_one) && r_upd) begin
                {r_hi, r_lo} <= w_commit;
            end
        end else if (start) begin
            case (w_cls)
                MD_CLS_MUL: begin
                    r_cnt          <= c_mult_lat;
                    {r_rhi, r_rlo} <= w_result;
                    r_upd          <= 1'b1;
`ifdef MD_MADD_EN
                    r_acc          <= (op == MD_MADD) || (op == MD_MADDU);
`endif
                end
                MD_CLS_DIV: begin
                    r_cnt          <= c_div_lat;
                    {r_rhi, r_rlo} <= w_result;
                    r_upd          <= !w_div_zero;
`ifdef MD_MADD_EN
                    r_acc          <= 1'b0;
`endif
                end
                MD_CLS_MOVE: begin
                    if (op == MD_MTHI) begin
                        r_hi <= a;
                    end else begin
                        r_lo <= a;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = w_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module      : tb_md_unit
// Description : Self-checking bench for md_unit against an arithmetic model.
//               Honours MD_MADD_EN when compiled with it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit;

    localparam int ML = 5;
    localparam int DL = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: latency and new {hi,lo} from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic [31:0] nh, output logic [31:0] nl);
        longint          sp;
        longint unsigned up;
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        logic [63:0]     v;
        lat = 0;
        nh  = m_hi;
        nl  = m_lo;
        sa  = longint'($signed(x));
        sb  = longint'($signed(y));
        case (o)
            3'd0: begin sp = sa * sb; v = sp; {nh, nl} = v; lat = ML; end
            3'd1: begin up = longint'(x) * longint'(y); {nh, nl} = up; lat = ML; end
            3'd2: begin
                lat = DL;
                if (y != 0) begin
                    q = sa / sb; r = sa % sb;
                    v = q; nl = v[31:0];
                    v = r; nh = v[31:0];
                end
            end
            3'd3: begin
                lat = DL;
                if (y != 0) begin nl = x / y; nh = x % y; end
            end
            3'd4: nh = x;
            3'd5: nl = x;
            default: begin
`ifdef MD_MADD_EN
                if (o == 3'd6) begin sp = sa * sb; v = sp; end
                else begin up = longint'(x) * longint'(y); v = up; end
                {nh, nl} = {m_hi, m_lo} + v;
                lat = ML;
`endif
            end
        endcase
    endtask

    // Issue one op; inj>0 pulses a spurious start before the inj-th busy edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int inj);
        int          lat;
        logic [31:0] nh;
        logic [31:0] nl;
        model(o, x, y, lat, nh, nl);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
        for (int k = 1; k <= lat; k++) begin
            chk("busy_hold", {63'd0, busy}, 64'd1);
            chk("hilo_hold", {hi, lo}, {m_hi, m_lo});
            @(negedge clk);
            if (k == inj) begin
                start = 1'b1; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("busy_done", {63'd0, busy}, 64'd0);
        chk("hilo_result", {hi, lo}, {nh, nl});
        m_hi = nh;
        m_lo = nl;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          inj;

        reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(3'd0, 32'hFFFFFFFE, 32'd3, 0);
        chk("t1_mult", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        chk("t2_multu", {hi, lo}, 64'hFFFFFFFE_00000001);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0);
        chk("t3_div", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
        chk("t3_div_ovf", {hi, lo}, 64'h00000000_80000000);
        run_op(3'd4, 32'h11, 32'd0, 0);
        run_op(3'd5, 32'h22, 32'd0, 0);
        run_op(3'd3, 32'h5555, 32'd0, 0);
        chk("t4_divu_zero", {hi, lo}, 64'h00000011_00000022);
        run_op(3'd4, 32'h1234, 32'd0, 0);
        chk("t4_mthi", {hi, lo}, 64'h00001234_00000022);

        // Reset mid-MULT: clears immediately, nothing commits afterwards.
        run_op(3'd5, 32'hCAFE, 32'd0, 0);
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_busy", {63'd0, busy}, 64'd0);
        chk("t5_rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (ML + 2) @(posedge clk);
        #1;
        chk("t5_no_commit", {hi, lo}, 64'd0);
        chk("t5_idle", {63'd0, busy}, 64'd0);

        run_op(3'd2, 32'd100, 32'hFFFFFFFD, 4);
        chk("t5_div_inj", {hi, lo}, 64'h00000001_FFFFFFDF);

        run_op(3'd4, 32'd0, 32'd0, 0);
        run_op(3'd5, 32'hFFFFFFFF, 32'd0, 0);
        run_op(3'd7, 32'd1, 32'd1, 0);
`ifdef MD_MADD_EN
        chk("t6_maddu", {hi, lo}, 64'h00000001_00000000);
`else
        chk("t6_maddu_noop", {hi, lo}, 64'h00000000_FFFFFFFF);
`endif

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 9)) * (($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFFFFFF);
                default: ;
            endcase
            inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ML) : 0;
            run_op(ro, ra, rb, inj);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
